// File: rtl/glyph_sequencer.sv
// glyph_sequencer: writable GLYPHS x ROWS x COLS bitmap store that presents one
// glyph at a time on a packed row bus. Advances come from a hold timer (run)
// or a manual step. They are merged into a single pending request and applied
// only on a monitor frame boundary, so the panel never shows a torn glyph.
module glyph_sequencer #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int GLYPHS      = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    localparam int GW = (GLYPHS > 1) ? $clog2(GLYPHS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [GW-1:0]        wr_glyph,
    input  logic [RW-1:0]        wr_row,
    input  logic [COLS-1:0]      wr_data,
    input  logic                 run,
    input  logic                 step,
    input  logic                 frame_done,
    output logic [ROWS*COLS-1:0] rows,
    output logic [GW-1:0]        cur_glyph,
    output logic                 pending
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GLYPH_LAST = GW'(GLYPHS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [COLS-1:0]      r_store [GLYPHS][ROWS];
    logic [TW-1:0]        r_timer;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [ROWS*COLS-1:0] r_rows;
    logic [GW-1:0]        r_cur;

    logic                 w_wr_ok;
    logic                 w_timer_hit;
    logic                 w_req;
    logic                 w_advance;
    logic [GW-1:0]        w_next_glyph;
    logic [GW-1:0]        w_sel_idx;
    logic [ROWS*COLS-1:0] w_sel_rows;

    assign w_wr_ok      = wr_en && (int'(wr_glyph) < GLYPHS) && (int'(wr_row) < ROWS);
    assign w_timer_hit  = run && (r_timer == HOLD_LAST);
    assign w_req        = step || w_timer_hit;
    assign w_advance    = frame_done && (r_state == ARMED);
    assign w_next_glyph = (r_cur == GLYPH_LAST) ? '0 : r_cur + GW'(1);
    assign w_sel_idx    = w_advance ? w_next_glyph : r_cur;

    // Glyph store: range-checked single-row writes, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned g = 0; g < GLYPHS; g++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    r_store[g][r] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_store[wr_glyph][wr_row] <= wr_data;
        end
    end

    // Hold timer: free-runs while run is high, restarts whenever an advance lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_advance) begin
            r_timer <= '0;
        end else if (run) begin
            r_timer <= w_timer_hit ? '0 : r_timer + TW'(1);
        end
    end

    // Request FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request FSM next state: a request arriving with frame_done re-arms after
    // the frame consumes the old one, so it is neither lost nor applied twice.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = ARMED;
            ARMED:   if (frame_done) w_state_nxt = w_req ? ARMED : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Packed view of the glyph that the next frame boundary will latch.
    always_comb begin
        w_sel_rows = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            w_sel_rows[r*COLS +: COLS] = r_store[w_sel_idx][r];
        end
    end

    // Presented glyph: only updated at frame boundaries; reads the store before
    // any same-cycle write lands, so a write racing the frame shows next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rows <= '0;
            r_cur  <= '0;
        end else if (frame_done) begin
            r_rows <= w_sel_rows;
            r_cur  <= w_sel_idx;
        end
    end

    assign rows      = r_rows;
    assign cur_glyph = r_cur;
    assign pending   = (r_state == ARMED);

endmodule

// File: tb/tb_glyph_sequencer.sv
// Bench for glyph_sequencer: table of per-cycle vectors plus hand sequences for
// reset, hold timer and out-of-range writes. Expected outputs are queued when a
// cycle is driven and compared one clock later.
module tb_glyph_sequencer;

    // Main instance: 4 glyphs of 8x8, short hold period.
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_glyph = '0;
    logic [2:0]  wr_row = '0;
    logic [7:0]  wr_data = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        frame_done = 1'b0;
    logic [63:0] rows;
    logic [1:0]  cur_glyph;
    logic        pending;

    // Second instance: 5 glyphs of 6 rows, so out-of-range indices are expressible.
    logic        d2_wr_en = 1'b0;
    logic [2:0]  d2_wr_glyph = '0;
    logic [2:0]  d2_wr_row = '0;
    logic [7:0]  d2_wr_data = '0;
    logic        d2_run = 1'b0;
    logic        d2_step = 1'b0;
    logic        d2_fd = 1'b0;
    logic [47:0] d2_rows;
    logic [2:0]  d2_cur;
    logic        d2_pend;

    glyph_sequencer #(
        .ROWS(8), .COLS(8), .GLYPHS(4), .HOLD_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_glyph(wr_glyph),
        .wr_row(wr_row), .wr_data(wr_data), .run(run), .step(step),
        .frame_done(frame_done), .rows(rows), .cur_glyph(cur_glyph),
        .pending(pending)
    );

    glyph_sequencer #(
        .ROWS(6), .COLS(8), .GLYPHS(5), .HOLD_CYCLES(5)
    ) dut2 (
        .clk(clk), .reset(reset), .wr_en(d2_wr_en), .wr_glyph(d2_wr_glyph),
        .wr_row(d2_wr_row), .wr_data(d2_wr_data), .run(d2_run), .step(d2_step),
        .frame_done(d2_fd), .rows(d2_rows), .cur_glyph(d2_cur),
        .pending(d2_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [1:0]  wg;
        logic [2:0]  wr;
        logic [7:0]  wd;
        logic        st;
        logic        fd;
        logic [63:0] erows;
        logic [1:0]  ecur;
        logic        epend;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] rows;
        logic [2:0]  cur;
        logic        pend;
        bit          which;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [7:0]  m_store [4][8];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [63:0] pack(int unsigned g);
        logic [63:0] v;
        v = '0;
        for (int unsigned r = 0; r < 8; r++) v[r*8 +: 8] = m_store[g][r];
        return v;
    endfunction

    // Expected values are taken before the model store sees the write.
    function automatic void add(logic we, logic [1:0] g, logic [2:0] r, logic [7:0] d,
                                logic st, logic fd, logic [63:0] er, logic [1:0] ec,
                                logic ep);
        vec_t v;
        v.wr_en = we; v.wg = g; v.wr = r; v.wd = d; v.st = st; v.fd = fd;
        v.erows = er; v.ecur = ec; v.epend = ep;
        vecs.push_back(v);
        if (we) m_store[g][r] = d;
    endfunction

    task automatic expect_out(string name, logic [63:0] r, logic [2:0] c, logic p, bit which);
        exp_t e;
        e.name = name; e.rows = r; e.cur = c; e.pend = p; e.which = which;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [63:0] ar;
        logic [2:0]  ac;
        logic        ap;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expectation queued for this sample");
            return;
        end
        e = exp_q.pop_front();
        if (e.which == 1'b0) begin
            ar = rows; ac = {1'b0, cur_glyph}; ap = pending;
        end else begin
            ar = {16'h0, d2_rows}; ac = d2_cur; ap = d2_pend;
        end
        if (ar !== e.rows || ac !== e.cur || ap !== e.pend) begin
            n_bad++;
            $display("FAIL %s: got rows=%h cur=%0d pending=%b, want rows=%h cur=%0d pending=%b",
                     e.name, ar, ac, ap, e.rows, e.cur, e.pend);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d2_cycle(string name, logic we, logic [2:0] g, logic [2:0] r,
                            logic [7:0] d, logic st, logic fd, logic [47:0] er,
                            logic [2:0] ec, logic ep);
        d2_wr_en = we; d2_wr_glyph = g; d2_wr_row = r; d2_wr_data = d;
        d2_step = st; d2_fd = fd;
        expect_out(name, {16'h0, er}, ec, ep, 1'b1);
        tick();
        d2_wr_en = 1'b0; d2_step = 1'b0; d2_fd = 1'b0;
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  g0 [8];
        logic [63:0] p_old;
        logic [47:0] g0_d2;

        g0 = '{8'h00, 8'h48, 8'h4A, 8'h48, 8'h7A, 8'h4A, 8'h4A, 8'h00};
        for (int unsigned g = 0; g < 4; g++)
            for (int unsigned r = 0; r < 8; r++) m_store[g][r] = '0;

        // ---- vector table ----
        for (int unsigned g = 0; g < 4; g++)
            for (int unsigned r = 0; r < 8; r++)
                add(1'b1, 2'(g), 3'(r), (g == 0) ? g0[r] : 8'(16 * g + r + 1),
                    1'b0, 1'b0, 64'h0, 2'd0, 1'b0);
        add(0, 0, 0, 0, 0, 1, 64'h004A4A7A484A4800, 2'd0, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(0), 2'd0, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(1), 2'd1, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(1), 2'd1, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(2), 2'd2, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(2), 2'd2, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(3), 2'd3, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(3), 2'd3, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(0), 2'd0, 1'b0);
        // step with frame_done while idle: no advance, stays armed
        add(0, 0, 0, 0, 1, 1, pack(0), 2'd0, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(1), 2'd1, 1'b0);
        // two steps merge into one advance
        add(0, 0, 0, 0, 1, 0, pack(1), 2'd1, 1'b1);
        add(0, 0, 0, 0, 1, 0, pack(1), 2'd1, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(2), 2'd2, 1'b0);
        add(0, 0, 0, 0, 0, 1, pack(2), 2'd2, 1'b0);
        // step with frame_done while armed: advance once, re-armed
        add(0, 0, 0, 0, 1, 0, pack(2), 2'd2, 1'b1);
        add(0, 0, 0, 0, 1, 1, pack(3), 2'd3, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(0), 2'd0, 1'b0);
        // edit the displayed glyph: visible only after the next frame
        p_old = pack(0);
        add(1, 2'd0, 3'd3, 8'hFF, 0, 0, p_old, 2'd0, 1'b0);
        add(0, 0, 0, 0, 0, 0, p_old, 2'd0, 1'b0);
        add(0, 0, 0, 0, 0, 1, pack(0), 2'd0, 1'b0);
        // write racing frame_done latches the pre-write value
        add(1, 2'd0, 3'd5, 8'h11, 0, 1, pack(0), 2'd0, 1'b0);
        add(0, 0, 0, 0, 0, 1, pack(0), 2'd0, 1'b0);
        p_old = pack(0);
        add(1, 2'd1, 3'd0, 8'hC3, 0, 0, p_old, 2'd0, 1'b0);
        add(0, 0, 0, 0, 1, 0, p_old, 2'd0, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(1), 2'd1, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(1), 2'd1, 1'b1);
        add(0, 0, 0, 0, 0, 1, pack(2), 2'd2, 1'b0);
        add(0, 0, 0, 0, 1, 0, pack(2), 2'd2, 1'b1);

        // ---- reset state ----
        reset = 1'b1;
        #2;
        expect_out("reset_state", 64'h0, 3'd0, 1'b0, 1'b0);
        check_pop();
        expect_out("reset_state_d2", 64'h0, 3'd0, 1'b0, 1'b1);
        check_pop();
        reset = 1'b0;

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].wr_en; wr_glyph = vecs[i].wg; wr_row = vecs[i].wr;
            wr_data = vecs[i].wd; step = vecs[i].st; frame_done = vecs[i].fd;
            expect_out($sformatf("vec%0d", i), vecs[i].erows, {1'b0, vecs[i].ecur},
                       vecs[i].epend, 1'b0);
            tick();
            wr_en = 1'b0; step = 1'b0; frame_done = 1'b0;
            check_pop();
        end

        // ---- reset while armed on glyph 2: outputs clear without a clock ----
        reset = 1'b1;
        #1;
        expect_out("reset_async", 64'h0, 3'd0, 1'b0, 1'b0);
        check_pop();
        step = 1'b1;
        wr_en = 1'b1; wr_glyph = 2'd0; wr_row = 3'd0; wr_data = 8'hAA;
        expect_out("reset_held", 64'h0, 3'd0, 1'b0, 1'b0);
        tick();
        step = 1'b0; wr_en = 1'b0;
        check_pop();

        // ---- hold timer: run high from reset release ----
        reset = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            expect_out($sformatf("timer_c%0d", k), 64'h0, 3'd0, (k >= 5), 1'b0);
            tick();
            check_pop();
        end
        run = 1'b0;
        frame_done = 1'b1;
        expect_out("timer_advance", 64'h0, 3'd1, 1'b0, 1'b0);
        tick();
        check_pop();
        expect_out("timer_once", 64'h0, 3'd1, 1'b0, 1'b0);
        tick();
        frame_done = 1'b0;
        check_pop();

        // ---- out-of-range writes on the 5x6 instance ----
        g0_d2 = 48'h0000_5A00_0000;
        d2_cycle("oor_inrange_wr", 1, 3'd0, 3'd3, 8'h5A, 0, 0, 48'h0, 3'd0, 1'b0);
        d2_cycle("oor_glyph5",     1, 3'd5, 3'd3, 8'hFF, 0, 0, 48'h0, 3'd0, 1'b0);
        d2_cycle("oor_glyph7",     1, 3'd7, 3'd3, 8'hEE, 0, 0, 48'h0, 3'd0, 1'b0);
        d2_cycle("oor_row6",       1, 3'd0, 3'd6, 8'h77, 0, 0, 48'h0, 3'd0, 1'b0);
        d2_cycle("oor_row7",       1, 3'd0, 3'd7, 8'h66, 0, 0, 48'h0, 3'd0, 1'b0);
        d2_cycle("oor_frame",      0, 3'd0, 3'd0, 8'h00, 0, 1, g0_d2, 3'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            d2_cycle($sformatf("oor_step%0d", k), 0, 0, 0, 0, 1, 0,
                     (k == 1) ? g0_d2 : 48'h0, 3'(k - 1), 1'b1);
            d2_cycle($sformatf("oor_adv%0d", k), 0, 0, 0, 0, 0, 1,
                     (k == 5) ? g0_d2 : 48'h0, 3'(k % 5), 1'b0);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
